// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon state type, linear-layer rotation table and rotate helper
package ascon_pkg;
  localparam int WORD_WIDTH = 64;
  localparam int NUM_WORDS = 5;
  localparam int SHW = $clog2(WORD_WIDTH);
  localparam int LD_INV_ROUNDS = 6;
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ldl_fsm_t;
  // forward rotation pair (a_w, b_w) for each word S0..S4
  localparam logic [SHW-1:0] LD_ROT [NUM_WORDS][2] = '{
    '{6'd19, 6'd28}, '{6'd61, 6'd39}, '{6'd1, 6'd6}, '{6'd10, 6'd17}, '{6'd7, 6'd41}
  };
  // a zero amount makes the left shift span the full word, leaving x unchanged
  function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x, input logic [SHW-1:0] s);
    return (x >> s) | (x << (WORD_WIDTH - int'(s)));
  endfunction
endpackage

// File: rtl/ldl_inv_round.sv
// ldl_inv_round: one combinational round of the inverse Ascon linear layer
//   state_i : working state in
//   round_i : round index k (0..5); rotations use (a_w << k) mod 64
//   state_o : state after the round
module ldl_inv_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [2:0]   round_i,
  output ascon_state_t state_o
);
  // the 6-bit shifted amount truncates naturally, giving the mod-64 reduction
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    logic [SHW-1:0] ra, rb;
    assign ra = LD_ROT[w][0] << round_i;
    assign rb = LD_ROT[w][1] << round_i;
    assign state_o[w] = state_i[w] ^ rotr(state_i[w], ra) ^ rotr(state_i[w], rb);
  end
endmodule

// File: rtl/inverse_linear_diffusion_layer.sv
// inverse_linear_diffusion_layer: iterative 6-round inverse of the Ascon linear layer
//   clk_i/rst_ni              : clock, async active-low reset
//   in_valid_i/in_ready_o     : input handshake, state_array_i captured on accept
//   out_valid_o/out_ready_i   : output handshake, state_array_o held until taken
//   busy_o                    : high outside IDLE
module inverse_linear_diffusion_layer
  import ascon_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  ascon_state_t state_array_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_array_o,
  output logic         busy_o
);
  localparam logic [2:0] LAST = 3'(LD_INV_ROUNDS - 1);
  ldl_fsm_t st;
  logic [2:0] cnt;
  ascon_state_t work, round_out;
  ldl_inv_round u_round (.state_i(work), .round_i(cnt), .state_o(round_out));
  assign state_array_o = work;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st          <= IDLE;
      cnt         <= '0;
      work        <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid_i) begin
          work       <= state_array_i;
          cnt        <= '0;
          st         <= RUN;
          in_ready_o <= 1'b0;
          busy_o     <= 1'b1;
        end
        RUN: begin
          work <= round_out;
          cnt  <= cnt == LAST ? '0 : cnt + 3'd1;
          if (cnt == LAST) begin
            st          <= DONE;
            out_valid_o <= 1'b1;
          end
        end
        DONE: if (out_ready_i) begin
          st          <= IDLE;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          st          <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inverse_linear_diffusion_layer.sv
// tb_inverse_linear_diffusion_layer: directed and round-trip checks of the inverse linear layer
module tb_inverse_linear_diffusion_layer;
  import ascon_pkg::*;
  logic clk_i = 1'b0, rst_ni = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic in_ready_o, out_valid_o, busy_o;
  ascon_state_t state_array_i = '0, state_array_o;
  int tests = 0, fails = 0;
  bit keep_valid = 1'b0;
  int ra [5] = '{19, 61, 1, 10, 7};
  int rb [5] = '{28, 39, 6, 17, 41};
  always #5 clk_i = ~clk_i;
  inverse_linear_diffusion_layer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .state_array_i(state_array_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .state_array_o(state_array_o), .busy_o(busy_o)
  );
  function automatic logic [63:0] rr(input logic [63:0] x, input int s);
    logic [127:0] d;
    d = {x, x} >> s;
    return d[63:0];
  endfunction
  function automatic ascon_state_t fwd(input ascon_state_t x);
    ascon_state_t r;
    r = '0;
    for (int w = 0; w < 5; w++) r[w] = x[w] ^ rr(x[w], ra[w]) ^ rr(x[w], rb[w]);
    return r;
  endfunction
  function automatic ascon_state_t rnd_state();
    ascon_state_t r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction
  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 320'(in_ready_o), 320'(1));
    check({tag, "_out_valid"}, 320'(out_valid_o), 320'(0));
    check({tag, "_busy"}, 320'(busy_o), 320'(0));
  endtask
  task automatic start(input ascon_state_t din);
    int n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    check("in_ready_before_accept", 320'(in_ready_o), 320'(1));
    state_array_i = din;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (!keep_valid) in_valid_i = 1'b0;
    check("busy_after_accept", 320'(busy_o), 320'(1));
    check("in_ready_after_accept", 320'(in_ready_o), 320'(0));
  endtask
  task automatic finish_op(input ascon_state_t exp, input bit bp, input string tag);
    int lat = 0;
    int k = 0;
    bit hs = 1'b0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 320'(lat), 320'(6));
    while (!hs && k < 40) begin
      check({tag, "_data"}, state_array_o, exp);
      check({tag, "_valid"}, 320'(out_valid_o), 320'(1));
      check({tag, "_in_ready_done"}, 320'(in_ready_o), 320'(0));
      out_ready_i = (bp && k < 39) ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_ready_i;
      @(posedge clk_i);
      #1;
      k++;
    end
    out_ready_i = 1'b0;
    check_idle({tag, "_after_hs"});
  endtask
  initial begin
    ascon_state_t din, exp, y1, y2;
    int seen;
    repeat (2) @(posedge clk_i);
    #1;
    check_idle("reset");
    check("reset_state", state_array_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_idle("post_reset");
    check("post_reset_state", state_array_o, '0);
    start('0);
    finish_op('0, 1'b0, "zero");
    din = '0;
    exp = '0;
    din[2] = 64'h8400000000000001;
    exp[2] = 64'h0000000000000001;
    start(din);
    finish_op(exp, 1'b0, "bit_s2");
    din = '0;
    exp = '0;
    din[0] = 64'h0000201000000001;
    exp[0] = 64'h0000000000000001;
    start(din);
    finish_op(exp, 1'b1, "bit_s0");
    for (int i = 0; i < 1000; i++) begin
      y1 = rnd_state();
      start(fwd(y1));
      finish_op(y1, 1'b1, "roundtrip");
    end
    keep_valid = 1'b1;
    y1 = rnd_state();
    y2 = rnd_state();
    start(fwd(y1));
    state_array_i = fwd(y2);
    finish_op(y1, 1'b1, "held_valid_first");
    start(fwd(y2));
    finish_op(y2, 1'b1, "held_valid_second");
    keep_valid = 1'b0;
    in_valid_i = 1'b0;
    y1 = rnd_state();
    start(fwd(y1));
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_idle("mid_run_reset");
    check("mid_run_reset_state", state_array_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o) seen++;
    end
    check("no_output_after_reset", 320'(seen), 320'(0));
    y2 = rnd_state();
    start(fwd(y2));
    finish_op(y2, 1'b1, "after_reset_op");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
